// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative signed multiply/divide unit.
// Build option: define MULT_DIV_DIVZERO_EXC_EN for the divide-by-zero short-circuit and div_zero flag.
package mult_div_unit_pkg;

   localparam int unsigned MDU_WIDTH = 32;
   localparam int unsigned MDU_CNT_W = 6;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MULT = 3'd1,
      S_DIV  = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } mdu_state_e;

endpackage

// File: rtl/mult_div_step.sv
// One iteration of the multiply/divide datapath: a radix-2 Booth step or a
// restoring-division step on magnitudes, chosen by i_mode_div.
module mult_div_step
   import mult_div_unit_pkg::*;
#(
   parameter int unsigned WIDTH = MDU_WIDTH
) (
   input  logic               i_mode_div,
   input  logic [2*WIDTH:0]   i_acc,
   input  logic [WIDTH-1:0]   i_opnd,
   output logic [2*WIDTH:0]   o_acc
);

   logic [WIDTH:0]   w_hi_ext;
   logic [WIDTH:0]   w_op_ext;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH-1:0] w_diff;
   logic             w_ge;

   // One extra sign bit keeps the Booth partial sum exact for the most negative multiplicand.
   assign w_hi_ext = {i_acc[2*WIDTH], i_acc[2*WIDTH:WIDTH+1]};
   assign w_op_ext = {i_opnd[WIDTH-1], i_opnd};

   always_comb begin
      w_sum = w_hi_ext;
      case (i_acc[1:0])
         2'b01:   w_sum = w_hi_ext + w_op_ext;
         2'b10:   w_sum = w_hi_ext - w_op_ext;
         default: w_sum = w_hi_ext;
      endcase
   end

   assign w_shift = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]};
   assign w_ge    = (w_shift >= {1'b0, i_opnd});
   assign w_diff  = w_shift[WIDTH-1:0] - i_opnd;

   always_comb begin
      if (i_mode_div) begin
         o_acc = {1'b0, (w_ge ? w_diff : w_shift[WIDTH-1:0]), i_acc[WIDTH-2:0], w_ge};
      end else begin
         o_acc = {w_sum, i_acc[WIDTH:1]};
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide unit for the MIPS HI/LO registers.
// Build option: MULT_DIV_DIVZERO_EXC_EN enables the one-cycle divide-by-zero path and div_zero.
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int unsigned WIDTH = MDU_WIDTH,
   parameter int unsigned CNT_W = MDU_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_mult,
   input  logic             start_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   localparam int unsigned AW = 2*WIDTH+1;

   mdu_state_e       r_state, w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [AW-1:0]    r_acc;
   logic [AW-1:0]    w_step;
   logic [WIDTH-1:0] r_opnd, r_hi, r_lo;
   logic [WIDTH-1:0] w_abs_a, w_abs_b, w_quo, w_rem;
   logic             r_neg_q, r_neg_r, r_bzero;
   logic             w_last, w_go_mult, w_go_div, w_mode_div;

   assign w_go_mult  = (r_state == S_IDLE) && start_mult;
   assign w_go_div   = (r_state == S_IDLE) && !start_mult && start_div;
   assign w_last     = (r_cnt == CNT_W'(WIDTH-1));
   assign w_mode_div = (r_state == S_DIV);
   assign w_abs_a    = a[WIDTH-1] ? ('0 - a) : a;
   assign w_abs_b    = b[WIDTH-1] ? ('0 - b) : b;
   assign w_quo      = r_acc[WIDTH-1:0];
   assign w_rem      = r_acc[2*WIDTH-1:WIDTH];
   assign hi         = r_hi;
   assign lo         = r_lo;

   mult_div_step #(.WIDTH(WIDTH)) u_step (
      .i_mode_div (w_mode_div),
      .i_acc      (r_acc),
      .i_opnd     (r_opnd),
      .o_acc      (w_step)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      busy     = (r_state != S_IDLE);
      done     = (r_state == S_DONE);
      div_zero = 1'b0;
`ifdef MULT_DIV_DIVZERO_EXC_EN
      div_zero = (r_state == S_DONE) && r_bzero;
`endif
      case (r_state)
         S_IDLE: begin
            if (start_mult) begin
               w_next = S_MULT;
            end else if (start_div) begin
               w_next = S_DIV;
`ifdef MULT_DIV_DIVZERO_EXC_EN
               if (b == '0) w_next = S_DONE;
`endif
            end
         end
         S_MULT:  if (w_last) w_next = S_DONE;
         S_DIV:   if (w_last) w_next = S_FIX;
         S_FIX:   w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt   <= '0;
         r_acc   <= '0;
         r_opnd  <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_bzero <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_go_mult) begin
                  r_cnt   <= '0;
                  r_acc   <= {{WIDTH{1'b0}}, b, 1'b0};
                  r_opnd  <= a;
                  r_bzero <= 1'b0;
               end else if (w_go_div) begin
                  r_cnt   <= '0;
                  r_acc   <= {1'b0, {WIDTH{1'b0}}, w_abs_a};
                  r_opnd  <= w_abs_b;
                  r_neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
                  r_neg_r <= a[WIDTH-1];
                  r_bzero <= (b == '0);
               end
            end
            S_MULT, S_DIV: begin
               r_acc <= w_step;
               r_cnt <= r_cnt + CNT_W'(1);
               if ((r_state == S_MULT) && w_last) begin
                  r_hi <= w_step[2*WIDTH:WIDTH+1];
                  r_lo <= w_step[WIDTH:1];
               end
            end
            S_FIX: begin
               // A zero divisor leaves the all-ones quotient unsigned so lo reads 0xFFFF...
               r_lo <= (r_neg_q && !r_bzero) ? ('0 - w_quo) : w_quo;
               r_hi <= r_neg_r ? ('0 - w_rem) : w_rem;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (table of vectors plus corner sequences).
// Expectations for divide-by-zero follow MULT_DIV_DIVZERO_EXC_EN when it is defined.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset, start_mult, start_div;
   logic [31:0] a, b, hi, lo;
   logic        busy, done, div_zero;

   int checks   = 0;
   int failures = 0;

   mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk        (clk),
      .reset      (reset),
      .start_mult (start_mult),
      .start_div  (start_div),
      .a          (a),
      .b          (b),
      .hi         (hi),
      .lo         (lo),
      .busy       (busy),
      .done       (done),
      .div_zero   (div_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          op;      // 0 mult, 1 div, 2 both requests
      logic [31:0] av, bv, eh, el;
      int          lat;
      logic        edz;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic do_op(input logic m, input logic d, input logic [31:0] av, input logic [31:0] bv,
                        output int lat, output logic [31:0] h, output logic [31:0] l,
                        output logic dz, output int hold_bad, output int busy_bad);
      logic [31:0] ph, pl;
      int cyc;
      ph = hi; pl = lo; hold_bad = 0; busy_bad = 0;
      @(negedge clk); start_mult = m; start_div = d; a = av; b = bv;
      @(posedge clk); #1; start_mult = 1'b0; start_div = 1'b0;
      cyc = 1;
      while (done !== 1'b1 && cyc < 100) begin
         if (busy !== 1'b1) busy_bad++;
         if (hi !== ph || lo !== pl) hold_bad++;
         @(posedge clk); #1; cyc++;
      end
      lat = (done === 1'b1) ? cyc : -1;
      if (busy !== 1'b1) busy_bad++;
      h = hi; l = lo; dz = div_zero;
      @(posedge clk); #1;
      if (busy !== 1'b0 || done !== 1'b0) busy_bad++;
   endtask

   initial begin
      int          lat, hold_bad, busy_bad, n_done, first;
      logic [31:0] h, l, rh, rl;
      logic        dz;

      vecs[0] = '{0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 33, 1'b0};
      vecs[1] = '{0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33, 1'b0};
      vecs[2] = '{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 33, 1'b0};
      vecs[3] = '{1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 34, 1'b0};
      vecs[4] = '{1, 32'd100,      32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 34, 1'b0};
      vecs[5] = '{1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34, 1'b0};
      vecs[6] = '{2, 32'd6,        32'd4,        32'h00000000, 32'h00000018, 33, 1'b0};
      vecs[7] = '{0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 33, 1'b0};
`ifdef MULT_DIV_DIVZERO_EXC_EN
      vecs[8] = '{1, 32'd5,        32'd0,        32'h00000001, 32'h23456780, 1,  1'b1};
      vecs[9] = '{1, 32'hFFFFFFFB, 32'd0,        32'h00000001, 32'h23456780, 1,  1'b1};
`else
      vecs[8] = '{1, 32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 34, 1'b0};
      vecs[9] = '{1, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 34, 1'b0};
`endif

      reset = 1'b1; start_mult = 1'b0; start_div = 1'b0; a = '0; b = '0;
      #3;
      chk("rst_hi", hi, 32'h0);
      chk("rst_lo", lo, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_done", {31'b0, done}, 32'h0);
      chk("rst_divzero", {31'b0, div_zero}, 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 10; i++) begin
         do_op(vecs[i].op != 1, vecs[i].op != 0, vecs[i].av, vecs[i].bv, lat, h, l, dz, hold_bad, busy_bad);
         chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
         chk($sformatf("v%0d_hi", i), h, vecs[i].eh);
         chk($sformatf("v%0d_lo", i), l, vecs[i].el);
         chk($sformatf("v%0d_divzero", i), {31'b0, dz}, {31'b0, vecs[i].edz});
         chk($sformatf("v%0d_hold", i), hold_bad, 32'd0);
         chk($sformatf("v%0d_busy", i), busy_bad, 32'd0);
      end

      // Simultaneous requests, plus a start_div pulse while busy that must be ignored.
      @(negedge clk); start_mult = 1'b1; start_div = 1'b1; a = 32'd6; b = 32'd4;
      @(posedge clk); #1; start_mult = 1'b0; start_div = 1'b0;
      n_done = 0; first = -1; rh = '0; rl = '0;
      for (int c = 1; c <= 80; c++) begin
         start_div = (c == 10);
         if (c == 10) begin a = 32'd9; b = 32'd3; end
         if (done === 1'b1) begin
            n_done++;
            if (first < 0) begin first = c; rh = hi; rl = lo; end
         end
         @(posedge clk); #1;
      end
      start_div = 1'b0;
      chk("arb_latency", first, 32'd33);
      chk("arb_hi", rh, 32'h0);
      chk("arb_lo", rl, 32'd24);
      chk("arb_done_count", n_done, 32'd1);
      chk("arb_idle_after", {31'b0, busy}, 32'h0);

      // Asynchronous reset in the middle of a divide.
      @(negedge clk); start_div = 1'b1; a = 32'd100; b = 32'hFFFFFFF9;
      @(posedge clk); #1; start_div = 1'b0;
      for (int c = 1; c < 15; c++) begin @(posedge clk); #1; end
      chk("mid_busy_before", {31'b0, busy}, 32'h1);
      chk("mid_lo_before", lo, 32'd24);
      reset = 1'b1;
      #1;
      chk("mid_rst_hi", hi, 32'h0);
      chk("mid_rst_lo", lo, 32'h0);
      chk("mid_rst_busy", {31'b0, busy}, 32'h0);
      @(negedge clk); reset = 1'b0;
      n_done = 0;
      for (int c = 0; c < 40; c++) begin
         if (done === 1'b1) n_done++;
         @(posedge clk); #1;
      end
      chk("mid_rst_no_done", n_done, 32'd0);

      do_op(1'b1, 1'b0, 32'd2, 32'd3, lat, h, l, dz, hold_bad, busy_bad);
      chk("post_rst_latency", lat, 32'd33);
      chk("post_rst_hi", h, 32'h0);
      chk("post_rst_lo", l, 32'd6);
      chk("post_rst_busy", busy_bad, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
